// File: rtl/banner_scroll_ctrl_if.sv
// Control, message-write and display-window signals of the rotating seven-segment banner.
// The controller takes the slave view; whatever drives the controls takes the master view.
interface banner_scroll_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CHAR_W     = 5
);
  logic                         msg_wr_en;
  logic [3:0]                   msg_wr_addr;
  logic [CHAR_W-1:0]            msg_wr_data;
  logic [4:0]                   msg_len;
  logic                         start;
  logic                         stop;
  logic                         clear;
  logic                         dir;
  logic                         step;
  logic [NUM_DIGITS*CHAR_W-1:0] window;
  logic [3:0]                   offset;
  logic                         tick;
  logic                         running;

  modport master (
    output msg_wr_en,
    output msg_wr_addr,
    output msg_wr_data,
    output msg_len,
    output start,
    output stop,
    output clear,
    output dir,
    output step,
    input  window,
    input  offset,
    input  tick,
    input  running
  );

  modport slave (
    input  msg_wr_en,
    input  msg_wr_addr,
    input  msg_wr_data,
    input  msg_len,
    input  start,
    input  stop,
    input  clear,
    input  dir,
    input  step,
    output window,
    output offset,
    output tick,
    output running
  );
endinterface

// File: rtl/banner_scroll_ctrl.sv
// Rotating banner sequencer: message buffer, step-rate clock-enable, circular read offset
// and a registered NUM_DIGITS-character window for the segment mux/decoder.
module banner_scroll_ctrl #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned STEP_HZ    = 1,
  parameter int unsigned MSG_LEN    = 16,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CHAR_W     = 5
) (
  input logic                 clk,
  input logic                 rst,
  banner_scroll_ctrl_if.slave bus
);

  localparam int unsigned DIV_VAL = CLK_HZ / STEP_HZ - 1;
  localparam int unsigned CNT_W   = $clog2(DIV_VAL + 1);
  localparam int unsigned AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned WIN_W   = NUM_DIGITS * CHAR_W;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_VAL);
  localparam logic [4:0]       MAX_LEN = 5'(MSG_LEN);

  if (CLK_HZ / STEP_HZ < 2) begin : g_chk_rate
    $error("CLK_HZ/STEP_HZ must be at least 2");
  end
  if (MSG_LEN == 0 || MSG_LEN > 16 || (MSG_LEN & (MSG_LEN - 1)) != 0) begin : g_chk_len
    $error("MSG_LEN must be a power of 2 no larger than 16");
  end
  if (NUM_DIGITS == 0 || NUM_DIGITS > MSG_LEN) begin : g_chk_digits
    $error("NUM_DIGITS must be in 1..MSG_LEN");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        offset_q, offset_d;
  logic [CHAR_W-1:0] mem_q [MSG_LEN];
  logic [CHAR_W-1:0] mem_d [MSG_LEN];
  logic [WIN_W-1:0]  window_q, window_d;

  logic       tick;
  logic       advance;
  logic [4:0] len_eff;
  logic [4:0] off_inc;
  logic [3:0] off_adv;
  logic [AW-1:0] wr_idx;

  // msg_len is clamped to 1..MSG_LEN so every modulo and wrap below stays in range.
  always_comb begin
    len_eff = bus.msg_len;
    if (bus.msg_len == 5'd0) begin
      len_eff = 5'd1;
    end else if (bus.msg_len > MAX_LEN) begin
      len_eff = MAX_LEN;
    end
  end

  // clear beats stop, stop beats start; stop outside RUN simply holds the state.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = StIdle;
    end else if (bus.stop) begin
      if (state_q == StRun) begin
        state_d = StPause;
      end
    end else if (bus.start) begin
      state_d = StRun;
    end
  end

  assign tick = (state_q == StRun) && (cnt_q == CNT_MAX);

  // Counting only while RUN persists also zeroes the counter on the cycle start is taken.
  always_comb begin
    cnt_d = '0;
    if (state_q == StRun && state_d == StRun) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    off_inc = {1'b0, offset_q} + 5'd1;
    if (!bus.dir) begin
      off_adv = (off_inc == len_eff) ? 4'd0 : off_inc[3:0];
    end else begin
      off_adv = (offset_q == 4'd0) ? 4'(len_eff - 5'd1) : offset_q - 4'd1;
    end
  end

  assign advance = (state_q == StRun) ? tick : bus.step;

  // An offset left beyond a shortened message snaps home before any step is applied.
  always_comb begin
    offset_d = offset_q;
    if (bus.clear) begin
      offset_d = '0;
    end else if ({1'b0, offset_q} >= len_eff) begin
      offset_d = '0;
    end else if (advance) begin
      offset_d = off_adv;
    end
  end

  assign wr_idx = bus.msg_wr_addr[AW-1:0];

  always_comb begin
    mem_d = mem_q;
    if (bus.msg_wr_en) begin
      mem_d[wr_idx] = bus.msg_wr_data;
    end
  end

  // Digit 0 is leftmost and sits in the MSBs; short messages repeat across the digits.
  always_comb begin
    window_d = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      window_d[(NUM_DIGITS - 1 - i) * CHAR_W +: CHAR_W] =
          mem_q[AW'(({2'b00, offset_q} + 6'(i)) % {1'b0, len_eff})];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      offset_q <= '0;
      window_q <= '1;
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        mem_q[i] <= '1;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      window_q <= window_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.window  = window_q;
  assign bus.offset  = offset_q;
  assign bus.tick    = tick;
  assign bus.running = (state_q == StRun);

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Directed bench for banner_scroll_ctrl with a 5-cycle step period (CLK_HZ=10, STEP_HZ=2).
module tb_banner_scroll_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  banner_scroll_ctrl_if #(.NUM_DIGITS(4), .CHAR_W(5)) bus ();

  banner_scroll_ctrl #(
    .CLK_HZ    (10),
    .STEP_HZ   (2),
    .MSG_LEN   (16),
    .NUM_DIGITS(4),
    .CHAR_W    (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired got running got %0b want finish", bus.running);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] win(input logic [4:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic ctrl(input logic s_start, s_stop, s_clear, s_step);
    bus.start = s_start;
    bus.stop  = s_stop;
    bus.clear = s_clear;
    bus.step  = s_step;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    bus.step  = 1'b0;
  endtask

  task automatic write_char(input logic [3:0] a, input logic [4:0] d);
    bus.msg_wr_en   = 1'b1;
    bus.msg_wr_addr = a;
    bus.msg_wr_data = d;
    cyc();
    bus.msg_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++;
    if (bus.offset !== 4'd0) begin
      errors++; $display("FAIL reset_offset got %0d want 0", bus.offset);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++; $display("FAIL reset_running got %0b want 0", bus.running);
    end
    checks++;
    if (bus.tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got %0b want 0", bus.tick);
    end
    checks++;
    if (bus.window !== 20'hFFFFF) begin
      errors++; $display("FAIL reset_window got %h want fffff", bus.window);
    end
    cyc();
    checks++;
    if (bus.tick !== 1'b0 || bus.window !== 20'hFFFFF) begin
      errors++; $display("FAIL idle_hold got tick %0b win %h want 0 fffff", bus.tick, bus.window);
    end
  endtask

  task automatic test_run_left();
    int         exp_off [6] = '{1, 2, 3, 4, 5, 0};
    logic [3:0] cur = 4'd0;
    logic       exp_t;
    for (int a = 0; a < 6; a++) write_char(4'(a), 5'(a));
    bus.msg_len = 5'd6;
    bus.dir     = 1'b0;
    cyc();
    checks++;
    if (bus.window !== win(5'd0, 5'd1, 5'd2, 5'd3)) begin
      errors++; $display("FAIL left_win0 got %h want %h", bus.window, win(0, 1, 2, 3));
    end
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.running !== 1'b1 || bus.tick !== 1'b0) begin
      errors++; $display("FAIL left_start got run %0b tick %0b want 1 0", bus.running, bus.tick);
    end
    for (int j = 0; j < 6; j++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc();
        exp_t = (c == 4);
        checks++;
        if (bus.tick !== exp_t) begin
          errors++; $display("FAIL left_tick j%0d c%0d got %0b want %0b", j, c, bus.tick, exp_t);
        end
        if (c == 1 && cur == 4'd4) begin
          checks++;
          if (bus.window !== win(5'd4, 5'd5, 5'd0, 5'd1)) begin
            errors++; $display("FAIL left_win4 got %h want %h", bus.window, win(4, 5, 0, 1));
          end
        end
      end
      cyc();
      checks++;
      if (bus.offset !== 4'(exp_off[j])) begin
        errors++; $display("FAIL left_offset j%0d got %0d want %0d", j, bus.offset, exp_off[j]);
      end
      cur = 4'(exp_off[j]);
    end
  endtask

  task automatic test_run_right();
    int         exp_off [6] = '{5, 4, 3, 2, 1, 0};
    logic [3:0] cur = 4'd0;
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.running !== 1'b0 || bus.offset !== 4'd0) begin
      errors++; $display("FAIL clear_run got run %0b off %0d want 0 0", bus.running, bus.offset);
    end
    bus.dir = 1'b1;
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc();
        if (c == 1 && cur == 4'd5) begin
          checks++;
          if (bus.window !== win(5'd5, 5'd0, 5'd1, 5'd2)) begin
            errors++; $display("FAIL right_win5 got %h want %h", bus.window, win(5, 0, 1, 2));
          end
        end
      end
      checks++;
      if (bus.tick !== 1'b1) begin
        errors++; $display("FAIL right_tick j%0d got %0b want 1", j, bus.tick);
      end
      cyc();
      checks++;
      if (bus.offset !== 4'(exp_off[j])) begin
        errors++; $display("FAIL right_offset j%0d got %0d want %0d", j, bus.offset, exp_off[j]);
      end
      cur = 4'(exp_off[j]);
    end
  endtask

  task automatic test_pause_step_resume();
    logic exp_t;
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);
    bus.dir = 1'b0;
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc();
    checks++;
    if (bus.offset !== 4'd2) begin
      errors++; $display("FAIL pause_pre_offset got %0d want 2", bus.offset);
    end
    ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.running !== 1'b0 || bus.tick !== 1'b0) begin
      errors++; $display("FAIL pause_stop got run %0b tick %0b want 0 0", bus.running, bus.tick);
    end
    for (int c = 0; c < 6; c++) begin
      cyc();
      checks++;
      if (bus.tick !== 1'b0 || bus.offset !== 4'd2) begin
        errors++; $display("FAIL pause_hold got tick %0b off %0d want 0 2", bus.tick, bus.offset);
      end
    end
    ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.offset !== 4'd3) begin
      errors++; $display("FAIL pause_step got %0d want 3", bus.offset);
    end
    cyc();
    checks++;
    if (bus.window !== win(5'd3, 5'd4, 5'd5, 5'd0)) begin
      errors++; $display("FAIL pause_win got %h want %h", bus.window, win(3, 4, 5, 0));
    end
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      exp_t = (c == 4);
      checks++;
      if (bus.tick !== exp_t || bus.offset !== 4'd3) begin
        errors++; $display("FAIL resume_tick c%0d got tick %0b off %0d want %0b 3",
                           c, bus.tick, bus.offset, exp_t);
      end
    end
    cyc();
    checks++;
    if (bus.offset !== 4'd4) begin
      errors++; $display("FAIL resume_offset got %0d want 4", bus.offset);
    end
  endtask

  task automatic test_simultaneous();
    ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.running !== 1'b0) begin
      errors++; $display("FAIL start_stop got run %0b want 0", bus.running);
    end
    repeat (6) cyc();
    checks++;
    if (bus.running !== 1'b0 || bus.offset !== 4'd4) begin
      errors++; $display("FAIL start_stop_hold got run %0b off %0d want 0 4",
                         bus.running, bus.offset);
    end
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    ctrl(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.running !== 1'b0 || bus.offset !== 4'd0) begin
      errors++; $display("FAIL clear_start got run %0b off %0d want 0 0", bus.running, bus.offset);
    end
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.offset !== 4'd0 || bus.running !== 1'b1) begin
      errors++; $display("FAIL step_in_run got off %0d run %0b want 0 1", bus.offset, bus.running);
    end
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    checks++;
    if (bus.tick !== 1'b0) begin
      errors++; $display("FAIL rerun_early got tick %0b want 0", bus.tick);
    end
    cyc();
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++; $display("FAIL rerun_tick got tick %0b want 1", bus.tick);
    end
    cyc();
    checks++;
    if (bus.offset !== 4'd1) begin
      errors++; $display("FAIL rerun_offset got %0d want 1", bus.offset);
    end
  endtask

  task automatic test_len_bounds();
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);
    bus.dir = 1'b1;
    ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.offset !== 4'd5) begin
      errors++; $display("FAIL idle_step_back got %0d want 5", bus.offset);
    end
    bus.msg_len = 5'd3;
    cyc();
    checks++;
    if (bus.offset !== 4'd0) begin
      errors++; $display("FAIL shrink_len got %0d want 0", bus.offset);
    end
    bus.msg_len = 5'd6;
    ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    bus.msg_len = 5'd3;
    ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.offset !== 4'd0) begin
      errors++; $display("FAIL shrink_over_step got %0d want 0", bus.offset);
    end
    cyc();
    checks++;
    if (bus.window !== win(5'd0, 5'd1, 5'd2, 5'd0)) begin
      errors++; $display("FAIL len3_win got %h want %h", bus.window, win(0, 1, 2, 0));
    end
    write_char(4'd0, 5'd9);
    cyc();
    bus.msg_len = 5'd0;
    cyc();
    checks++;
    if (bus.window !== win(5'd9, 5'd9, 5'd9, 5'd9)) begin
      errors++; $display("FAIL len0_win got %h want %h", bus.window, win(9, 9, 9, 9));
    end
    bus.msg_len = 5'd2;
    cyc();
    checks++;
    if (bus.window !== win(5'd9, 5'd1, 5'd9, 5'd1)) begin
      errors++; $display("FAIL len2_win got %h want %h", bus.window, win(9, 1, 9, 1));
    end
    bus.msg_len = 5'd20;
    cyc();
    checks++;
    if (bus.window !== win(5'd9, 5'd1, 5'd2, 5'd3)) begin
      errors++; $display("FAIL len20_win got %h want %h", bus.window, win(9, 1, 2, 3));
    end
    ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.offset !== 4'd15) begin
      errors++; $display("FAIL len20_wrap got %0d want 15", bus.offset);
    end
    cyc();
    checks++;
    if (bus.window !== win(5'd31, 5'd9, 5'd1, 5'd2)) begin
      errors++; $display("FAIL len20_win15 got %h want %h", bus.window, win(31, 9, 1, 2));
    end
  endtask

  task automatic test_write_in_run();
    bus.msg_len = 5'd6;
    bus.dir     = 1'b0;
    cyc();
    checks++;
    if (bus.offset !== 4'd0) begin
      errors++; $display("FAIL regrow_offset got %0d want 0", bus.offset);
    end
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    write_char(4'd1, 5'd17);
    checks++;
    if (bus.window !== win(5'd9, 5'd1, 5'd2, 5'd3)) begin
      errors++; $display("FAIL wr_run_early got %h want %h", bus.window, win(9, 1, 2, 3));
    end
    cyc();
    checks++;
    if (bus.window !== win(5'd9, 5'd17, 5'd2, 5'd3)) begin
      errors++; $display("FAIL wr_run_win got %h want %h", bus.window, win(9, 17, 2, 3));
    end
    ctrl(1'b0, 1'b1, 1'b0, 1'b0);
    bus.step = 1'b1;
    write_char(4'd2, 5'd20);
    bus.step = 1'b0;
    checks++;
    if (bus.offset !== 4'd1) begin
      errors++; $display("FAIL wr_step_offset got %0d want 1", bus.offset);
    end
    cyc();
    checks++;
    if (bus.window !== win(5'd17, 5'd20, 5'd3, 5'd4)) begin
      errors++; $display("FAIL wr_step_win got %h want %h", bus.window, win(17, 20, 3, 4));
    end
  endtask

  task automatic test_reset_in_run();
    int n = 0;
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    while (bus.tick !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (bus.tick !== 1'b1) begin
      errors++; $display("FAIL rst_run_tick_wait got %0b want 1 within 20", bus.tick);
    end
    cyc();
    checks++;
    if (bus.offset !== 4'd2) begin
      errors++; $display("FAIL rst_run_pre got %0d want 2", bus.offset);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (bus.running !== 1'b0 || bus.offset !== 4'd0 || bus.tick !== 1'b0) begin
      errors++; $display("FAIL rst_run_state got run %0b off %0d tick %0b want 0 0 0",
                         bus.running, bus.offset, bus.tick);
    end
    checks++;
    if (bus.window !== 20'hFFFFF) begin
      errors++; $display("FAIL rst_run_window got %h want fffff", bus.window);
    end
    cyc();
    cyc();
    checks++;
    if (bus.window !== 20'hFFFFF) begin
      errors++; $display("FAIL rst_run_buffer got %h want fffff", bus.window);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.msg_wr_en   = 1'b0;
    bus.msg_wr_addr = 4'd0;
    bus.msg_wr_data = 5'd0;
    bus.msg_len     = 5'd6;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.clear       = 1'b0;
    bus.dir         = 1'b0;
    bus.step        = 1'b0;
    test_reset();
    test_run_left();
    test_run_right();
    test_pause_step_resume();
    test_simultaneous();
    test_len_bounds();
    test_write_in_run();
    test_reset_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
